// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-to-hazard-controller bus: register addresses and
//               control bits in, forwarding/stall/flush controls out.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] RS_D;
    logic [REG_AW-1:0] RT_D;
    logic [REG_AW-1:0] RS_E;
    logic [REG_AW-1:0] RT_E;
    logic [REG_AW-1:0] WriteReg_E;
    logic [REG_AW-1:0] WriteReg_M;
    logic [REG_AW-1:0] WriteReg_W;
    logic              RegWrite_E;
    logic              RegWrite_M;
    logic              RegWrite_W;
    logic              MemToReg_E;
    logic              MemToReg_M;
    logic              BranchD;
    logic              MulStart_E;
    logic              MemAccess_M;
    logic              DMemReady;

    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              ForwardAD;
    logic              ForwardBD;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              FlushE;
    logic              FlushM;
    logic              FlushW;
    logic              MulBusy;
    logic [CNT_W-1:0]  LdStallCnt;
    logic [CNT_W-1:0]  BrStallCnt;
    logic [CNT_W-1:0]  MulStallCnt;
    logic [CNT_W-1:0]  MemStallCnt;

    modport master (
        output RS_D, RT_D, RS_E, RT_E, WriteReg_E, WriteReg_M, WriteReg_W,
        output RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M,
        output BranchD, MulStart_E, MemAccess_M, DMemReady,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        input  StallF, StallD, StallE, StallM, FlushE, FlushM, FlushW, MulBusy,
        input  LdStallCnt, BrStallCnt, MulStallCnt, MemStallCnt
    );

    modport slave (
        input  RS_D, RT_D, RS_E, RT_E, WriteReg_E, WriteReg_M, WriteReg_W,
        input  RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M,
        input  BranchD, MulStart_E, MemAccess_M, DMemReady,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        output StallF, StallD, StallE, StallM, FlushE, FlushM, FlushW, MulBusy,
        output LdStallCnt, BrStallCnt, MulStallCnt, MemStallCnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Forwarding, load-use/branch stall, multi-cycle EX op and
//               data-memory wait control for the five-stage MIPS pipeline.
//               Define HAZARD_PERF_EN to build saturating stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_ctrl_if.slave  bus
);
    localparam int                 c_mcnt_w    = $clog2(MUL_LAT);
    localparam logic [c_mcnt_w-1:0] c_mcnt_load = c_mcnt_w'(MUL_LAT - 2);
    localparam logic [REG_AW-1:0]  c_reg_zero  = {REG_AW{1'b0}};

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MULWAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [c_mcnt_w-1:0] mcnt_q, mcnt_d;

    logic w_mem_stall;
    logic w_ld_stall;
    logic w_br_hit_e;
    logic w_br_hit_m;
    logic w_br_stall;
    logic w_mul_stall;
    logic w_in_run;

    assign w_in_run    = (state_q == RUN);
    assign w_mem_stall = bus.MemAccess_M & ~bus.DMemReady;

    assign w_ld_stall  = bus.MemToReg_E & (bus.WriteReg_E != c_reg_zero)
                       & ((bus.RS_D == bus.WriteReg_E) | (bus.RT_D == bus.WriteReg_E));

    assign w_br_hit_e  = bus.RegWrite_E & (bus.WriteReg_E != c_reg_zero)
                       & ((bus.WriteReg_E == bus.RS_D) | (bus.WriteReg_E == bus.RT_D));
    assign w_br_hit_m  = bus.MemToReg_M & (bus.WriteReg_M != c_reg_zero)
                       & ((bus.WriteReg_M == bus.RS_D) | (bus.WriteReg_M == bus.RT_D));
    assign w_br_stall  = bus.BranchD & (w_br_hit_e | w_br_hit_m);

    // The op holds EX on its first cycle and every MULWAIT cycle but the last.
    assign w_mul_stall = (w_in_run & bus.MulStart_E) | (~w_in_run & (mcnt_q != '0));

    logic [1:0] w_fwd_ae, w_fwd_be;
    logic       w_fwd_ad, w_fwd_bd;

    always_comb begin
        w_fwd_ae = 2'b00;
        if (bus.RegWrite_M & (bus.RS_E != c_reg_zero) & (bus.RS_E == bus.WriteReg_M))
            w_fwd_ae = 2'b10;
        else if (bus.RegWrite_W & (bus.RS_E != c_reg_zero) & (bus.RS_E == bus.WriteReg_W))
            w_fwd_ae = 2'b01;

        w_fwd_be = 2'b00;
        if (bus.RegWrite_M & (bus.RT_E != c_reg_zero) & (bus.RT_E == bus.WriteReg_M))
            w_fwd_be = 2'b10;
        else if (bus.RegWrite_W & (bus.RT_E != c_reg_zero) & (bus.RT_E == bus.WriteReg_W))
            w_fwd_be = 2'b01;

        w_fwd_ad = bus.RegWrite_M & (bus.RS_D != c_reg_zero) & (bus.RS_D == bus.WriteReg_M);
        w_fwd_bd = bus.RegWrite_M & (bus.RT_D != c_reg_zero) & (bus.RT_D == bus.WriteReg_M);
    end

    assign bus.ForwardAE = reset_n ? w_fwd_ae : 2'b00;
    assign bus.ForwardBE = reset_n ? w_fwd_be : 2'b00;
    assign bus.ForwardAD = reset_n & w_fwd_ad;
    assign bus.ForwardBD = reset_n & w_fwd_bd;
    assign bus.StallF    = reset_n & (w_mem_stall | w_mul_stall | w_ld_stall | w_br_stall);
    assign bus.StallD    = reset_n & (w_mem_stall | w_mul_stall | w_ld_stall | w_br_stall);
    assign bus.StallE    = reset_n & (w_mem_stall | w_mul_stall);
    assign bus.StallM    = reset_n & w_mem_stall;
    assign bus.FlushW    = reset_n & w_mem_stall;
    assign bus.FlushM    = reset_n & w_mul_stall & ~w_mem_stall;
    assign bus.FlushE    = reset_n & (w_ld_stall | w_br_stall) & ~w_mul_stall & ~w_mem_stall;
    assign bus.MulBusy   = reset_n & ~w_in_run;

    // mcnt keeps counting through memstall; only the exit waits for memory.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        if (state_q == RUN) begin
            if (bus.MulStart_E & ~w_mem_stall) begin
                state_d = MULWAIT;
                mcnt_d  = c_mcnt_load;
            end
        end else begin
            if (mcnt_q != '0)
                mcnt_d = mcnt_q - 1'b1;
            else if (~w_mem_stall)
                state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] ld_cnt_q, br_cnt_q, mul_cnt_q, mem_cnt_q;

    // Only the highest-priority cause is charged for a given cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ld_cnt_q  <= '0;
            br_cnt_q  <= '0;
            mul_cnt_q <= '0;
            mem_cnt_q <= '0;
        end else if (w_mem_stall) begin
            if (~&mem_cnt_q) mem_cnt_q <= mem_cnt_q + 1'b1;
        end else if (w_mul_stall) begin
            if (~&mul_cnt_q) mul_cnt_q <= mul_cnt_q + 1'b1;
        end else if (w_ld_stall) begin
            if (~&ld_cnt_q) ld_cnt_q <= ld_cnt_q + 1'b1;
        end else if (w_br_stall) begin
            if (~&br_cnt_q) br_cnt_q <= br_cnt_q + 1'b1;
        end
    end

    assign bus.LdStallCnt  = ld_cnt_q;
    assign bus.BrStallCnt  = br_cnt_q;
    assign bus.MulStallCnt = mul_cnt_q;
    assign bus.MemStallCnt = mem_cnt_q;
`else
    assign bus.LdStallCnt  = {CNT_W{1'b0}};
    assign bus.BrStallCnt  = {CNT_W{1'b0}};
    assign bus.MulStallCnt = {CNT_W{1'b0}};
    assign bus.MemStallCnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl (MUL_LAT=4, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [13:0] outs;
        logic [15:0] cnts;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit   m_busy;
    int   m_cnt;
    int   m_ld, m_br, m_mul, m_mem;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] rs);
        if (bus.RegWrite_M && rs != 0 && rs == bus.WriteReg_M) return 2'b10;
        if (bus.RegWrite_W && rs != 0 && rs == bus.WriteReg_W) return 2'b01;
        return 2'b00;
    endfunction

    // {mem, mul, ld, br} causes for the present inputs and model state
    function automatic logic [3:0] causes();
        logic mem, mul, ld, br;
        mem = bus.MemAccess_M && !bus.DMemReady;
        mul = m_busy ? (m_cnt != 0) : bus.MulStart_E;
        ld  = bus.MemToReg_E && bus.WriteReg_E != 0 &&
              (bus.RS_D == bus.WriteReg_E || bus.RT_D == bus.WriteReg_E);
        br  = bus.BranchD &&
              ((bus.RegWrite_E && bus.WriteReg_E != 0 &&
                (bus.WriteReg_E == bus.RS_D || bus.WriteReg_E == bus.RT_D)) ||
               (bus.MemToReg_M && bus.WriteReg_M != 0 &&
                (bus.WriteReg_M == bus.RS_D || bus.WriteReg_M == bus.RT_D)));
        return {mem, mul, ld, br};
    endfunction

    function automatic exp_t predict(input string tag);
        exp_t e;
        logic [3:0] c;
        logic mem, mul, ld, br, any;
        c = causes();
        {mem, mul, ld, br} = c;
        any = mem | mul | ld | br;
        e.tag  = tag;
        e.outs = {fwd_e(bus.RS_E), fwd_e(bus.RT_E),
                  logic'(bus.RegWrite_M && bus.RS_D != 0 && bus.RS_D == bus.WriteReg_M),
                  logic'(bus.RegWrite_M && bus.RT_D != 0 && bus.RT_D == bus.WriteReg_M),
                  any, any, mem | mul, mem,
                  (ld | br) & ~mul & ~mem, mul & ~mem, mem, logic'(m_busy)};
        if (!reset_n) e.outs = '0;
`ifdef HAZARD_PERF_EN
        e.cnts = {4'(m_ld), 4'(m_br), 4'(m_mul), 4'(m_mem)};
`else
        e.cnts = '0;
`endif
        return e;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic model_update();
        logic mem, mul, ld, br;
        {mem, mul, ld, br} = causes();
        if (!reset_n) begin
            m_busy = 0; m_cnt = 0;
            m_ld = 0; m_br = 0; m_mul = 0; m_mem = 0;
        end else begin
            if (mem)      m_mem = sat_inc(m_mem);
            else if (mul) m_mul = sat_inc(m_mul);
            else if (ld)  m_ld  = sat_inc(m_ld);
            else if (br)  m_br  = sat_inc(m_br);
            if (!m_busy) begin
                if (bus.MulStart_E && !mem) begin
                    m_busy = 1; m_cnt = MUL_LAT - 2;
                end
            end else if (m_cnt != 0) begin
                m_cnt--;
            end else if (!mem) begin
                m_busy = 0;
            end
        end
    endtask

    task automatic step(input string tag);
        sb_q.push_back(predict(tag));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.RS_D = 0; bus.RT_D = 0; bus.RS_E = 0; bus.RT_E = 0;
        bus.WriteReg_E = 0; bus.WriteReg_M = 0; bus.WriteReg_W = 0;
        bus.RegWrite_E = 0; bus.RegWrite_M = 0; bus.RegWrite_W = 0;
        bus.MemToReg_E = 0; bus.MemToReg_M = 0; bus.BranchD = 0;
        bus.MulStart_E = 0; bus.MemAccess_M = 0; bus.DMemReady = 1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("%s_out", e.tag),
                  32'({bus.ForwardAE, bus.ForwardBE, bus.ForwardAD, bus.ForwardBD,
                       bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                       bus.FlushE, bus.FlushM, bus.FlushW, bus.MulBusy}),
                  32'(e.outs));
            check($sformatf("%s_cnt", e.tag),
                  32'({bus.LdStallCnt, bus.BrStallCnt, bus.MulStallCnt, bus.MemStallCnt}),
                  32'(e.cnts));
        end
    end

    initial begin
        m_busy = 0; m_cnt = 0; m_ld = 0; m_br = 0; m_mul = 0; m_mem = 0;
        idle();
        reset_n = 1'b0;
        @(posedge clk); #1;
        step("rst0");
        step("rst1");
        reset_n = 1'b1;

        bus.RS_E = 3; bus.WriteReg_M = 3; bus.RegWrite_M = 1;
        bus.WriteReg_W = 3; bus.RegWrite_W = 1;
        step("fwd_mem");
        bus.RS_E = 0;
        step("fwd_r0");
        bus.RT_E = 3; bus.RegWrite_M = 0;
        step("fwd_wb");
        bus.RS_D = 3; bus.RT_D = 3; bus.RegWrite_M = 1;
        step("fwd_d");

        idle();
        bus.MemToReg_E = 1; bus.WriteReg_E = 5; bus.RT_D = 5;
        step("ld");
        bus.WriteReg_E = 0; bus.RT_D = 0;
        step("ld_r0");

        idle();
        bus.BranchD = 1; bus.RegWrite_E = 1; bus.WriteReg_E = 7; bus.RS_D = 7;
        step("br_e");
        bus.RegWrite_E = 0; bus.MemToReg_M = 1; bus.WriteReg_M = 7;
        step("br_m");

        idle();
        bus.MulStart_E = 1;
        repeat (MUL_LAT) step("mul");
        bus.MulStart_E = 0;
        step("mul_done");

        bus.MulStart_E = 1;
        step("mm_start");
        step("mm_wait");
        bus.MemAccess_M = 1; bus.DMemReady = 0;
        repeat (3) step("mm_mem");
        bus.DMemReady = 1;
        step("mm_last");
        bus.MulStart_E = 0; bus.MemAccess_M = 0;
        step("mm_run");

        bus.MulStart_E = 1;
        step("ab_start");
        step("ab_wait");
        reset_n = 1'b0;
        step("ab_rst");
        reset_n = 1'b1; bus.MulStart_E = 0;
        step("ab_after");

        idle();
        bus.MemToReg_E = 1; bus.WriteReg_E = 5; bus.RS_D = 5;
        repeat (20) step("ld_sat");
        idle();
        step("ld_sat_end");

        for (int i = 0; i < 300; i++) begin
            bus.RS_D = REG_AW'($urandom_range(0, 3)); bus.RT_D = REG_AW'($urandom_range(0, 3));
            bus.RS_E = REG_AW'($urandom_range(0, 3)); bus.RT_E = REG_AW'($urandom_range(0, 3));
            bus.WriteReg_E = REG_AW'($urandom_range(0, 3));
            bus.WriteReg_M = REG_AW'($urandom_range(0, 3));
            bus.WriteReg_W = REG_AW'($urandom_range(0, 3));
            bus.RegWrite_E = 1'($urandom_range(0, 1)); bus.RegWrite_M = 1'($urandom_range(0, 1));
            bus.RegWrite_W = 1'($urandom_range(0, 1)); bus.MemToReg_E = 1'($urandom_range(0, 1));
            bus.MemToReg_M = 1'($urandom_range(0, 1)); bus.BranchD = 1'($urandom_range(0, 1));
            bus.MulStart_E = ($urandom_range(0, 3) == 0);
            bus.MemAccess_M = ($urandom_range(0, 2) == 0);
            bus.DMemReady = 1'($urandom_range(0, 1));
            reset_n = ($urandom_range(0, 49) != 0);
            step("rnd");
        end

        @(negedge clk); #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and stall controller for the five-stage pipelined MIPS core, the successor to the combinational hazard unit. It keeps EX/ID forwarding and load-use and branch stall detection, with `$r0` guards on every comparison. It adds a sequential stall FSM for a multi-cycle multiply/divide unit in EX and a data-memory wait handshake in MEM. Optional saturating per-cause stall counters support performance analysis.

## Interface
Parameters:
- REG_AW, 5, register address width.
- MUL_LAT, 4, cycles a multi-cycle op occupies EX; legal range is ≥2.
- CNT_W, 16, width of each stall performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- RS_D, RT_D  in  REG_AW  ID-stage source registers.
- RS_E, RT_E  in  REG_AW  EX-stage source registers.
- WriteReg_E, WriteReg_M, WriteReg_W  in  REG_AW  destination registers.
- RegWrite_E, RegWrite_M, RegWrite_W  in  1  register-write enables.
- MemToReg_E, MemToReg_M  in  1  load in EX / MEM.
- BranchD  in  1  branch in ID.
- MulStart_E  in  1  multi-cycle op in EX; held while that op stays in EX.
- MemAccess_M  in  1  load/store in MEM.
- DMemReady  in  1  data memory completes this cycle.
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = MEM, 01 = WB.
- ForwardAD, ForwardBD  out  1  forward MEM to branch comparator.
- StallF, StallD, StallE, StallM  out  1  hold stage register.
- FlushE, FlushM, FlushW  out  1  insert bubble into stage register.
- MulBusy  out  1  FSM in MULWAIT.
- LdStallCnt, BrStallCnt, MulStallCnt, MemStallCnt  out  CNT_W  stall counters.

## Operation
- Forwarding:
  - ForwardAE = 10 if RegWrite_M & RS_E≠0 & RS_E==WriteReg_M.
  - Otherwise ForwardAE = 01 if RegWrite_W & RS_E≠0 & RS_E==WriteReg_W.
  - Otherwise ForwardAE = 00.
  - ForwardBE is identical, using RT_E.
  - ForwardAD = RegWrite_M & RS_D≠0 & RS_D==WriteReg_M. ForwardBD uses RT_D.
- memstall = MemAccess_M & ~DMemReady.
- ldstall = MemToReg_E & WriteReg_E≠0 & (RS_D==WriteReg_E | RT_D==WriteReg_E).
- brstall = BranchD & [(RegWrite_E & WriteReg_E≠0 & WriteReg_E∈{RS_D,RT_D}) | (MemToReg_M & WriteReg_M≠0 & WriteReg_M∈{RS_D,RT_D})].
- FSM states and counter:
  - States are RUN and MULWAIT. Counter mcnt is ⌈log2 MUL_LAT⌉ bits wide.
  - RUN with MulStart_E & ~memstall: go to MULWAIT, load mcnt=MUL_LAT-2.
  - MULWAIT: mcnt decrements to 0 every cycle, including during memstall.
  - MULWAIT: leave for RUN only when mcnt==0 & ~memstall. If mcnt==0 and memstall is active, stay in MULWAIT.
- mulstall = (RUN & MulStart_E) | (MULWAIT & mcnt≠0).
- MulStart_E is ignored while in MULWAIT.
- Output equations, with priority memstall > mulstall > ldstall/brstall:
  - StallF = StallD = memstall | mulstall | ldstall | brstall.
  - StallE = memstall | mulstall.
  - StallM = FlushW = memstall.
  - FlushM = mulstall & ~memstall.
  - FlushE = (ldstall | brstall) & ~mulstall & ~memstall.
- Reset: while reset_n=0, all stall, flush and forward outputs are 0 and MulBusy=0. At the clock edge the FSM goes to RUN, mcnt to 0, and counters to 0.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the current state. There is no added latency.
- A multi-cycle op occupies EX for exactly MUL_LAT cycles when memstall is absent. StallE is high for MUL_LAT-1 of those cycles.
- In the cycle where mcnt==0 in MULWAIT, StallE=0 and the op advances.
- Every memstall cycle extends the freeze by one cycle, with the whole pipe held.
- Reset mid-MULWAIT aborts the op. The first cycle after reset is RUN with no stalls.

## Configuration
- HAZARD_PERF_EN defined:
  - Each counter increments by 1 per cycle for the highest-priority active cause only, in order mem > mul > ld > br.
  - Counters saturate at all-ones.
  - Counters clear on reset.
- HAZARD_PERF_EN undefined:
  - The counter ports are present and tied to 0.
  - No counter flops are built.

## Test plan
- RS_E=3, WriteReg_M=3, RegWrite_M=1, WriteReg_W=3, RegWrite_W=1 -> ForwardAE=10. Repeat with RS_E=0 -> ForwardAE=00.
- MemToReg_E=1, WriteReg_E=5, RT_D=5 -> StallF=StallD=FlushE=1, StallE=0. Repeat with WriteReg_E=0 -> no stall.
- MUL_LAT=4, MulStart_E held for 4 cycles -> StallE=1 for 3 cycles, then 0. FlushM=1 for 3 cycles. MulBusy=1 for cycles 2–4.
- Mul in MULWAIT with mcnt=1 and DMemReady=0 for 3 cycles -> StallM=FlushW=1 for 3 cycles, FSM holds MULWAIT at mcnt=0, then RUN one cycle after DMemReady=1.
- reset_n=0 during MULWAIT -> next cycle MulBusy=0, all stalls 0. With HAZARD_PERF_EN, all counters read 0.
- With HAZARD_PERF_EN and CNT_W=4, 20 load-use stall cycles -> LdStallCnt=15, which is saturated.
